// File: rtl/mem_stage_unit.sv
// mem_stage_unit: memory-stage data-access unit for the pipelined CPU.
// Performs sized (byte/half/word), aligned, little-endian loads and stores
// against an internal word-organised RAM with a fixed access latency, and
// holds the pipeline with stall while an access is in flight.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   mem_read      load request (M stage)
//   mem_write     store request (M stage), never together with mem_read
//   size          00 byte, 01 half, 10 word, 11 reserved (faults)
//   sign_ext      load extension: 1 sign, 0 zero (ignored for words)
//   addr          byte address
//   wdata         store data (low byte/half used for sb/sh)
//   rdata         registered, extended load result
//   stall         freezes F/D/E/M while high
//   misaligned    alignment fault, combinational in the request cycle
//   out_of_range  word index beyond MEM_WORDS, high in the DONE cycle
//
// Handshake: a request is mem_read|mem_write held stable by the pipeline
// for as long as stall is high; the access completes in the first cycle
// where stall is low again (DONE), and the pipeline advances at its end.
module mem_stage_unit #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        out_of_range
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        req;
  logic        fault;
  logic        in_range;
  logic        commit;
  logic [AW-1:0] word_idx;
  logic [1:0]  lane;
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rd_word;
  logic [31:0] load_val;
  logic [31:0] wr_word;
  logic [3:0]  wr_mask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign req      = mem_read | mem_write;
  assign word_idx = addr[AW+1:2];
  assign lane     = addr[1:0];
  assign in_range = (addr[31:2] < 30'(MEM_WORDS));

  always_comb begin
    fault = 1'b0;
    case (size)
      2'b00:   fault = 1'b0;
      2'b01:   fault = addr[0];
      2'b10:   fault = (addr[1:0] != 2'b00);
      default: fault = 1'b1;
    endcase
  end

  // Stall counts the request cycle itself, so the commit edge is the end of
  // the WAIT_CYCLES-th stalled cycle. cnt holds the stalled cycles still to
  // come; with WAIT_CYCLES == 1 the request cycle is also the commit cycle.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    stall        = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    commit       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (fault) begin
            misaligned = 1'b1;
          end else begin
            stall = 1'b1;
            if (WAIT_CYCLES <= 1) begin
              commit     = 1'b1;
              state_next = DONE;
            end else begin
              cnt_next   = CNT_INIT;
              state_next = BUSY;
            end
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt <= 4'd1) begin
          commit     = 1'b1;
          cnt_next   = 4'd0;
          state_next = DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      DONE: begin
        // Same instruction is still presented; req is ignored here.
        out_of_range = ~in_range;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset wins on any edge, including a would-be commit edge.
    if (rst) begin
      stall        = 1'b0;
      misaligned   = 1'b0;
      out_of_range = 1'b0;
      commit       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Store lane selection; data is replicated so each lane sees its byte.
  always_comb begin
    wr_mask = 4'b0000;
    wr_word = wdata;
    case (size)
      2'b00: begin
        wr_mask = 4'b0001 << lane;
        wr_word = {4{wdata[7:0]}};
      end
      2'b01: begin
        wr_mask = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata[15:0]}};
      end
      2'b10:   wr_mask = 4'b1111;
      default: wr_mask = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && mem_write && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  // Load extraction and extension.
  always_comb begin
    rd_word = mem[word_idx];
    ld_byte = rd_word[8*lane +: 8];
    ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (size)
      2'b00:   load_val = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{sign_ext & ld_half[15]}}, ld_half};
      default: load_val = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (commit && mem_read) begin
      rdata <= in_range ? load_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
module tb_mem_stage_unit;

  localparam int MEM_WORDS   = 1024;
  localparam int WAIT_CYCLES = 2;
  localparam int MAX_WAIT    = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misaligned;
  logic        out_of_range;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage_unit #(.MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .misaligned(misaligned),
    .out_of_range(out_of_range)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    size      = 2'b10;
    sign_ext  = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
  endtask

  // Present one access, count stalled cycles (bounded), then check the
  // DONE cycle. chk_rdata selects whether rdata is compared.
  task automatic access(input string tag, input logic rd, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd,
                        input logic chk_rdata, input logic [31:0] exp_rdata,
                        input logic exp_oor);
    int n;
    mem_read  = rd;
    mem_write = ~rd;
    size      = sz;
    sign_ext  = sx;
    addr      = a;
    wdata     = wd;
    #1;
    n = 0;
    while (stall && n < MAX_WAIT) begin
      n++;
      tick();
    end
    check({tag, " stall_cycles"}, 32'(n), 32'(WAIT_CYCLES));
    check({tag, " oor_done"}, {31'd0, out_of_range}, {31'd0, exp_oor});
    if (chk_rdata) check({tag, " rdata"}, rdata, exp_rdata);
    tick();
    idle_inputs();
    #1;
    check({tag, " idle_after"}, {30'd0, stall, out_of_range}, 32'd0);
  endtask

  task automatic misaligned_req(input string tag, input logic rd, input logic [1:0] sz,
                                input logic [31:0] a);
    mem_read  = rd;
    mem_write = ~rd;
    size      = sz;
    addr      = a;
    wdata     = 32'hFFFF_FFFF;
    #1;
    check({tag, " misaligned"}, {31'd0, misaligned}, 32'd1);
    check({tag, " stall"}, {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    #1;
    check({tag, " misaligned_drop"}, {31'd0, misaligned}, 32'd0);
    check({tag, " stall_after"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset rdata", rdata, 32'd0);
    check("reset flags", {29'd0, stall, misaligned, out_of_range}, 32'd0);

    // sw / lw basic
    access("sw 0x10", 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0);
    access("lw 0x10", 1'b1, 2'b10, 1'b0, 32'h10, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);

    // byte/half loads with extension
    access("sw 0x20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, 1'b0, 32'd0, 1'b0);
    access("lb 0x21", 1'b1, 2'b00, 1'b1, 32'h21, 32'd0, 1'b1, 32'h0000007F, 1'b0);
    access("lb 0x23", 1'b1, 2'b00, 1'b1, 32'h23, 32'd0, 1'b1, 32'hFFFFFF80, 1'b0);
    access("lbu 0x23", 1'b1, 2'b00, 1'b0, 32'h23, 32'd0, 1'b1, 32'h00000080, 1'b0);
    access("lh 0x22", 1'b1, 2'b01, 1'b1, 32'h22, 32'd0, 1'b1, 32'hFFFF80FF, 1'b0);
    access("lhu 0x20", 1'b1, 2'b01, 1'b0, 32'h20, 32'd0, 1'b1, 32'h00007F01, 1'b0);

    // partial stores
    access("sw 0x30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h11223344, 1'b0, 32'd0, 1'b0);
    access("sb 0x31", 1'b0, 2'b00, 1'b0, 32'h31, 32'h000000AA, 1'b0, 32'd0, 1'b0);
    access("sh 0x32", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0000BBCC, 1'b0, 32'd0, 1'b0);
    access("lw 0x30", 1'b1, 2'b10, 1'b0, 32'h30, 32'd0, 1'b1, 32'hBBCCAA44, 1'b0);

    // misaligned requests leave RAM untouched
    access("sw 0x40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h01020304, 1'b0, 32'd0, 1'b0);
    misaligned_req("lw 0x42", 1'b1, 2'b10, 32'h42);
    misaligned_req("sh 0x41", 1'b0, 2'b01, 32'h41);
    misaligned_req("rsvd 0x40", 1'b0, 2'b11, 32'h40);
    check("rdata held after misaligned", rdata, 32'hBBCCAA44);
    access("lw 0x40", 1'b1, 2'b10, 1'b0, 32'h40, 32'd0, 1'b1, 32'h01020304, 1'b0);

    // out of range
    access("sw 0x0", 1'b0, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 32'd0, 1'b0);
    access("sw oor", 1'b0, 2'b10, 1'b0, 32'(4*MEM_WORDS), 32'd5, 1'b0, 32'd0, 1'b1);
    access("lw oor", 1'b1, 2'b10, 1'b0, 32'(4*MEM_WORDS), 32'd0, 1'b1, 32'd0, 1'b1);
    access("lw 0x0", 1'b1, 2'b10, 1'b0, 32'h0, 32'd0, 1'b1, 32'hCAFEF00D, 1'b0);

    // reset on the commit edge aborts the store
    access("sw 0x50 zero", 1'b0, 2'b10, 1'b0, 32'h50, 32'd0, 1'b0, 32'd0, 1'b0);
    mem_write = 1'b1;
    size      = 2'b10;
    addr      = 32'h50;
    wdata     = 32'h12345678;
    tick();
    check("abort busy stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    tick();
    idle_inputs();
    rst = 1'b0;
    #1;
    check("abort rdata", rdata, 32'd0);
    check("abort flags", {29'd0, stall, misaligned, out_of_range}, 32'd0);
    access("lw 0x50", 1'b1, 2'b10, 1'b0, 32'h50, 32'd0, 1'b1, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
